// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and the
// bit-counter width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  // The counter must hold values up to WIDTH.
  function automatic int CNT_W(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow, purely combinational.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - b_in, LSB first,
// one bit per clock through a single full-subtractor cell and a borrow flop.
// Optional macro SERIAL_SUBTRACTOR_OVF_EN adds a signed-overflow output ovf.
import serial_sub_pkg::*;

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             ovf,
`endif
  output logic             b_out
);

  localparam int CW = CNT_W(WIDTH);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, diff_q;
  logic             borrow_q, bout_q;
  logic [CW-1:0]    cnt_q;
  logic             cell_d, cell_bout;
  logic             accept, last_bit;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // MSBs must be captured at accept because the operand registers shift away.
  logic a_msb_q, b_msb_q, ovf_q;
`endif

  full_subtractor u_fs (
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign accept   = start && (state_q == IDLE || state_q == DONE);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Next-state logic; DONE always leaves after one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand load on accept, then one bit per SHIFT cycle; results latch on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else if (accept) begin
      a_sr_q   <= a;
      b_sr_q   <= b;
      diff_q   <= '0;
      borrow_q <= b_in;
      cnt_q    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q  <= a[WIDTH-1];
      b_msb_q  <= b[WIDTH-1];
`endif
    end else if (state_q == SHIFT) begin
      a_sr_q   <= a_sr_q >> 1;
      b_sr_q   <= b_sr_q >> 1;
      diff_q   <= {cell_d, diff_q[WIDTH-1:1]};
      borrow_q <= cell_bout;
      cnt_q    <= cnt_q + CW'(1);
      if (last_bit) begin
        bout_q <= cell_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        // cell_d is the result MSB on the last bit.
        ovf_q  <= (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
      end
    end
  end

  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign diff  = diff_q;
  assign b_out = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed cases,
// back-to-back starts, mid-operation reset, exhaustive and random sweeps
// against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         b_in = 1'b0;
  logic         busy, done, b_out;
  logic [W-1:0] diff;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf   (ovf),
`endif
    .b_out (b_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned subtraction over W+1 bits gives {borrow, diff}.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
  endfunction

  // Reference: signed overflow when the true signed result leaves the W-bit range.
  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    int r;
    r = int'($signed(x)) - int'($signed(y)) - int'(bi);
    return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
  endfunction

  // One full operation from an idle/done state; checks busy each shift cycle,
  // done exactly W edges after accept, and the result.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbi, input string tag);
    logic [W:0] exp;
    exp = model(ta, tb, tbi);
    @(negedge clk);
    a = ta; b = tb; b_in = tbi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
    chk({tag, "_acc_busy"}, busy, 1);
    for (int k = 1; k <= W; k++) begin
      @(posedge clk); #1;
      if (k < W) begin
        chk({tag, "_busy"}, {busy, done}, 2'b10);
      end else begin
        chk({tag, "_done"}, {busy, done}, 2'b01);
        chk({tag, "_diff"}, diff, exp[W-1:0]);
        chk({tag, "_bout"}, b_out, exp[W]);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk({tag, "_ovf"}, ovf, model_ovf(ta, tb, tbi));
`endif
      end
    end
  endtask

  initial begin
    logic [W:0] exp;
    int pulses;

    // Reset state
    #12;
    chk("rst_outs", {busy, done, diff, b_out}, '0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("idle_after_rst", {busy, done}, 2'b00);

    // Directed cases
    run_op(4'b0111, 4'b0011, 1'b0, "d0");
    repeat (3) @(posedge clk);
    #1 chk("hold_diff", diff, 4'b0100);
    chk("hold_idle", {busy, done, b_out}, 3'b000);
    run_op(4'b0011, 4'b0111, 1'b0, "d1");
    run_op(4'b0000, 4'b0000, 1'b1, "d2");
    run_op(4'b0111, 4'b1000, 1'b0, "d3");
    run_op(4'b1000, 4'b0000, 1'b1, "d4");

    // Back-to-back: start held 20 cycles; operands scrambled between accepts
    @(negedge clk);
    start = 1'b1; a = 4'b1111; b = 4'b1111; b_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if ((i + 1) % 5 == 0) begin
        a = 4'b1111; b = 4'b1111; b_in = 1'b0;
      end else begin
        a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
      end
      if (i % 5 == 4) begin
        pulses++;
        chk("b2b_done", {busy, done}, 2'b01);
        chk("b2b_res", {b_out, diff}, 5'b0_0000);
      end else begin
        chk("b2b_busy", {busy, done}, 2'b10);
      end
    end
    start = 1'b0;
    chk("b2b_pulses", pulses, 4);
    @(posedge clk); #1 chk("b2b_end_idle", {busy, done}, 2'b00);

    // Reset at E2 of 0110-0001 aborts the operation
    @(negedge clk);
    a = 4'b0110; b = 4'b0001; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort_outs", {busy, done, diff, b_out}, '0);
    @(negedge clk); rst_n = 1'b1;
    done_cnt = 0;
    repeat (6) @(posedge clk);
    #1 chk("abort_no_done", done_cnt, 0);
    chk("abort_idle", {busy, diff}, '0);
    run_op(4'b1001, 4'b0010, 1'b0, "post_abort");

    // Exhaustive sweep
    @(negedge clk); done_cnt = 0;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int z = 0; z < 2; z++)
          run_op(W'(x), W'(y), 1'(z), "exh");
    @(negedge clk);
    chk("exh_done_cnt", done_cnt, 512);

    // Random operands with random idle gaps
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_op(W'($urandom), W'($urandom), 1'($urandom), "rnd");
    end

    // Spot-check a model value on the last result holding while idle
    exp = model(4'b0101, 4'b1010, 1'b1);
    run_op(4'b0101, 4'b1010, 1'b1, "last");
    repeat (2) @(posedge clk);
    #1 chk("last_hold", {b_out, diff}, exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing diff = a - b - b_in, one bit per clock, LSB first, through a registered borrow.
- Arithmetic inverse and sequential counterpart of the team's combinational ripple adder.
- Start/busy/done handshake for use inside multi-cycle datapaths.
- Trades area for latency: one full-subtractor cell regardless of width.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend; captured when start is accepted.
- b  input  WIDTH  subtrahend; captured when start is accepted.
- b_in  input  1  borrow-in; captured when start is accepted.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; diff/b_out valid from this cycle.
- diff  output  WIDTH  result a - b - b_in mod 2^WIDTH.
- b_out  output  1  borrow-out; high when a < b + b_in (unsigned).

Interface (already decided):
- One clock; reset is asynchronous and active-low.
- Ports named clk and rst_n.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, diff=0, b_out=0.
  - Internal shift registers, borrow flop and bit counter cleared.
- States:
  - IDLE: start=1 -> SHIFT; else stay.
  - SHIFT: after the WIDTH-th bit is processed -> DONE; else stay.
  - DONE: start=1 -> SHIFT; else IDLE. DONE lasts exactly one cycle.
- Accept edge E0 (start=1 in IDLE or DONE):
  - Load a_sr<=a, b_sr<=b, borrow<=b_in, cnt<=0.
  - Clear the diff shift register.
- SHIFT edges E1..E_WIDTH, each:
  - d = a_sr[0]^b_sr[0]^borrow.
  - borrow <= (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&borrow).
  - Shift a_sr/b_sr right; shift d into diff MSB; cnt++.
- At E_WIDTH: state<=DONE, b_out<=final borrow, diff holds the full result.
- Latency: done is high in the cycle following E_WIDTH, i.e. WIDTH edges after the accept edge.
- Throughput: back-to-back start in DONE gives one result per WIDTH+1 cycles.
- busy=1 exactly in SHIFT; done=1 exactly in DONE.
- diff and b_out:
  - Must not be sampled while busy (diff is a shift register and holds partial bits).
  - Hold their value after DONE until the next accepted start.
- start while busy is ignored; no queuing. Operand inputs are don't-care except at the accept edge.
- rst_n asserted mid-SHIFT aborts immediately: no done pulse, outputs zero. After deassertion, the first start-accept edge is the first rising clk edge with start=1.
- Wrap-around: result is modulo 2^WIDTH; b_out carries the underflow. No saturation.

Optional Feature:
- Macro SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), signed two's-complement overflow.
  - ovf = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), using the captured a and b MSBs.
  - Registered at E_WIDTH; same hold, reset and abort rules as b_out.
- Undefined: port absent; no extra flops.

Decomposition:
- Package serial_sub_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t.
  - Localparam function CNT_W(WIDTH) = $clog2(WIDTH+1).
- Sub-module full_subtractor: combinational 1-bit cell.
  - Inputs x, y, bin; outputs d, bout.
  - Instantiated once in the top.

Test Plan (WIDTH=4):
- a=0111, b=0011, b_in=0 -> done 4 edges after start; diff=0100, b_out=0.
- a=0011, b=0111, b_in=0 -> diff=1100, b_out=1 (ovf=0 with macro).
- a=0000, b=0000, b_in=1 -> diff=1111, b_out=1. Separately, a=0111, b=1000 -> diff=1111, ovf=1 with macro.
- Start held high for 20 cycles with a=1111, b=1111 -> back-to-back results diff=0000, b_out=0.
  - Operands changed while busy must not alter the in-flight result.
  - done pulses every 5 cycles.
- rst_n pulsed low at edge E2 of a 0110-0001 operation -> busy=0, done never pulses, diff=0.
  - Next start with 1001-0010 -> diff=0111, b_out=0.
- Exhaustive: all 16x16x2 combinations against the model {b_out,diff} = {1'b0,a} - b - b_in (5-bit).
  - Zero mismatches; done count equals 512.
